// File: rtl/utf16_byte_encoder.sv
// utf16_byte_encoder: code points to a UTF-16 byte stream (BE/LE) with a saturating replacement count.
// Define UTF16_BOM_EN to emit a byte-order mark once after each reset.
module utf16_byte_encoder #(
    parameter int CNT_W = 16,
    parameter logic [15:0] REPL = 16'hFFFD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      cp_in,
    input  logic             cp_err,
    input  logic             cp_valid,
    output logic             cp_ready,
    input  logic             cbe,
    output logic [7:0]       dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic             busy,
    output logic [CNT_W-1:0] sub_cnt
);
    logic [3:0][7:0] r_b;
    logic [2:0]      r_n;
    logic [1:0]      r_i;
    logic            r_valid;
    logic            r_last;
    logic [7:0]      r_dout;
    logic            w_bom_pend;
    logic            w_load;
    logic            w_out;
    logic            w_bad;
    logic            w_pair;
    logic [19:0]     w_v;
    logic [15:0]     w_u0;
    logic [15:0]     w_u1;
    logic [3:0][7:0] w_b;
    logic [1:0]      w_inext;

`ifdef UTF16_BOM_EN
    logic r_bom_req;
    logic r_bom_act;
    assign w_bom_pend = r_bom_req | r_bom_act;
`else
    assign w_bom_pend = 1'b0;
`endif

    assign cp_ready   = (~r_valid | (dout_ready & r_last)) & ~w_bom_pend;
    assign w_load     = cp_valid & cp_ready;
    assign w_out      = r_valid & dout_ready;
    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign dout_last  = r_last;
    assign busy       = r_valid | w_bom_pend;
    assign w_inext    = r_i + 2'd1;

    always_comb begin
        w_bad  = cp_err | (cp_in >= 32'h110000) | (cp_in >= 32'hD800 && cp_in <= 32'hDFFF);
        w_pair = ~w_bad & (cp_in >= 32'h10000);
        w_v    = 20'(cp_in - 32'h10000);
        w_u0   = w_bad ? REPL : w_pair ? (16'hD800 | {6'd0, w_v[19:10]}) : cp_in[15:0];
        w_u1   = 16'hDC00 | {6'd0, w_v[9:0]};
        w_b[0] = cbe ? w_u0[15:8] : w_u0[7:0];
        w_b[1] = cbe ? w_u0[7:0]  : w_u0[15:8];
        w_b[2] = cbe ? w_u1[15:8] : w_u1[7:0];
        w_b[3] = cbe ? w_u1[7:0]  : w_u1[15:8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_b     <= '0;
            r_n     <= '0;
            r_i     <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_dout  <= '0;
            sub_cnt <= '0;
`ifdef UTF16_BOM_EN
            r_bom_req <= 1'b1;
            r_bom_act <= 1'b0;
`endif
        end
`ifdef UTF16_BOM_EN
        else if (r_bom_req) begin
            r_bom_req <= 1'b0;
            r_bom_act <= 1'b1;
            r_b[0]    <= cbe ? 8'hFE : 8'hFF;
            r_b[1]    <= cbe ? 8'hFF : 8'hFE;
            r_n       <= 3'd2;
            r_i       <= '0;
            r_valid   <= 1'b1;
            r_last    <= 1'b0;
            r_dout    <= cbe ? 8'hFE : 8'hFF;
        end
`endif
        else if (w_load) begin
            r_b     <= w_b;
            r_n     <= w_pair ? 3'd4 : 3'd2;
            r_i     <= '0;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_dout  <= w_b[0];
            if (w_bad && !(&sub_cnt))
                sub_cnt <= sub_cnt + 1'b1;
        end else if (w_out) begin
            if (r_last) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_dout  <= '0;
                r_i     <= '0;
`ifdef UTF16_BOM_EN
                r_bom_act <= 1'b0;
`endif
            end else begin
                r_i    <= w_inext;
                r_dout <= r_b[w_inext];
                r_last <= ({1'b0, w_inext} == r_n - 3'd1);
            end
        end
    end
endmodule

// File: tb/tb_utf16_byte_encoder.sv
// tb_utf16_byte_encoder: directed vectors with hand-computed UTF-16 byte sequences.
module tb_utf16_byte_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cp_in = '0;
    logic        cp_err = 1'b0;
    logic        cp_valid = 1'b0;
    logic        cp_ready;
    logic        cbe = 1'b0;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic        dout_last;
    logic        busy;
    logic [15:0] sub_cnt;
    int          n_pass = 0;
    int          n_total = 0;

    utf16_byte_encoder dut (
        .clk(clk), .rst(rst), .cp_in(cp_in), .cp_err(cp_err), .cp_valid(cp_valid),
        .cp_ready(cp_ready), .cbe(cbe), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy), .sub_cnt(sub_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!cp_ready && t < 50) begin
            step();
            t++;
        end
        chk("ready", {31'd0, cp_ready}, 32'd1);
    endtask

    task automatic check_bytes(input string tag, input logic [31:0] exp, input int nb);
        for (int k = 0; k < nb; k++) begin
            chk({tag, "_byte"}, {24'd0, dout}, {24'd0, exp[31-8*k -: 8]});
            chk({tag, "_valid"}, {31'd0, dout_valid}, 32'd1);
            chk({tag, "_last"}, {31'd0, dout_last}, {31'd0, k == nb - 1});
            step();
        end
        chk({tag, "_idle"}, {31'd0, dout_valid}, 32'd0);
    endtask

    task automatic send(input string tag, input logic [31:0] cp, input logic err, input logic be,
                        input logic [31:0] exp, input int nb);
        cp_in = cp;
        cp_err = err;
        cbe = be;
        cp_valid = 1'b1;
        wait_ready();
        step();
        cp_valid = 1'b0;
        cp_err = 1'b0;
        check_bytes(tag, exp, nb);
    endtask

    task automatic after_reset();
        chk("rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_dout", {24'd0, dout}, 32'd0);
        chk("rst_cnt", {16'd0, sub_cnt}, 32'd0);
`ifdef UTF16_BOM_EN
        chk("bom_rdy0", {31'd0, cp_ready}, 32'd0);
        step();
        chk("bom_rdy1", {31'd0, cp_ready}, 32'd0);
        chk("bom_busy", {31'd0, busy}, 32'd1);
        chk("bom_b0", {24'd0, dout}, 32'hFF);
        chk("bom_l0", {31'd0, dout_last}, 32'd0);
        step();
        chk("bom_rdy2", {31'd0, cp_ready}, 32'd0);
        chk("bom_b1", {24'd0, dout}, 32'hFE);
        chk("bom_l1", {31'd0, dout_last}, 32'd1);
        step();
        chk("bom_done", {31'd0, dout_valid}, 32'd0);
        chk("bom_cnt", {16'd0, sub_cnt}, 32'd0);
`else
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_last", {31'd0, dout_last}, 32'd0);
`endif
        chk("rst_ready", {31'd0, cp_ready}, 32'd1);
    endtask

    initial begin
        cbe = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        after_reset();

        send("le_A", 32'h41, 1'b0, 1'b0, 32'h4100_0000, 2);
        chk("cnt0", {16'd0, sub_cnt}, 32'd0);
        send("be_smile", 32'h1F600, 1'b0, 1'b1, 32'hD83D_DE00, 4);
        send("le_smile", 32'h1F600, 1'b0, 1'b0, 32'h3DD8_00DE, 4);
        send("surr", 32'hD800, 1'b0, 1'b1, 32'hFFFD_0000, 2);
        send("range", 32'h110000, 1'b0, 1'b1, 32'hFFFD_0000, 2);
        send("err", 32'h41, 1'b1, 1'b1, 32'hFFFD_0000, 2);
        chk("cnt3", {16'd0, sub_cnt}, 32'd3);
        send("max_bmp", 32'hFFFF, 1'b0, 1'b1, 32'hFFFF_0000, 2);
        send("max_cp", 32'h10FFFF, 1'b0, 1'b1, 32'hDBFF_DFFF, 4);
        chk("cnt3b", {16'd0, sub_cnt}, 32'd3);

        // back-to-back 'A','B' then a stall inside 'B'
        cbe = 1'b1;
        cp_in = 32'h41;
        cp_valid = 1'b1;
        wait_ready();
        step();
        cp_in = 32'h42;
        cbe = 1'b0;
        chk("bb_a0", {24'd0, dout}, 32'h00);
        chk("bb_rdy0", {31'd0, cp_ready}, 32'd0);
        step();
        cbe = 1'b1;
        chk("bb_a1", {24'd0, dout}, 32'h41);
        chk("bb_rdy1", {31'd0, cp_ready}, 32'd1);
        step();
        cp_valid = 1'b0;
        cbe = 1'b0;
        chk("bb_b0", {24'd0, dout}, 32'h00);
        chk("bb_v", {31'd0, dout_valid}, 32'd1);
        dout_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_dout", {24'd0, dout}, 32'h00);
            chk("stall_rdy", {31'd0, cp_ready}, 32'd0);
            chk("stall_last", {31'd0, dout_last}, 32'd0);
        end
        dout_ready = 1'b1;
        step();
        chk("bb_b1", {24'd0, dout}, 32'h42);
        chk("bb_last", {31'd0, dout_last}, 32'd1);
        step();
        chk("bb_idle", {31'd0, dout_valid}, 32'd0);

        // reset in the middle of a surrogate pair
        cp_in = 32'h1F600;
        cbe = 1'b1;
        cp_valid = 1'b1;
        wait_ready();
        step();
        cp_valid = 1'b0;
        chk("mid_b0", {24'd0, dout}, 32'hD8);
        step();
        chk("mid_b1", {24'd0, dout}, 32'h3D);
        cbe = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        after_reset();
        send("le_e9", 32'hE9, 1'b0, 1'b0, 32'hE900_0000, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/utf16_byte_encoder.md
Name: utf16_byte_encoder

Overview:
Downstream stage of the UTF-8 codec. Consumes decoded code points plus an error flag over a valid/ready handshake. Re-encodes each one as UTF-16 and serialises the result into a byte stream with selectable byte order. Invalid input, surrogates and out-of-range code points become a replacement code unit, and each replacement is counted.

Parameters:
CNT_W, 16, width of the saturating replacement counter
REPL, 16'hFFFD, code unit emitted in place of unencodable input

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous active-high reset
cp_in  input  32  code point (character register value)
cp_err  input  1  upstream error (retry/invalid/overlong); forces replacement
cp_valid  input  1  cp_in/cp_err valid
cp_ready  output  1  block accepts a code point this cycle (combinational)
cbe  input  1  1 = UTF-16BE, 0 = UTF-16LE; sampled on acceptance
dout  output  8  byte output (registered)
dout_valid  output  1  dout holds a byte
dout_ready  input  1  consumer takes dout this cycle
dout_last  output  1  dout is the final byte of the current character
busy  output  1  bytes pending (dout_valid or BOM pending)
sub_cnt  output  CNT_W  number of replacements since reset, saturating

Behaviour:
- Registers: byte buffer b0..b3, byte count n (2 or 4), index i, latched byte order, sub_cnt.
- Transfer rules:
  - Input transfer = cp_valid & cp_ready.
  - Output transfer = dout_valid & dout_ready.
- cp_ready = ~dout_valid | (dout_ready & dout_last), and never while the BOM is pending. This gives full throughput with no bubble between characters.
- Latency: when a character is accepted at edge N, its first byte is on dout after edge N; dout_valid=1.
- Classification on acceptance, first match wins:
  - cp_err=1, cp_in>=32'h110000, or cp_in in D800..DFFF: one unit, REPL. sub_cnt increments unless it is already all-ones.
  - cp_in<32'h10000: one unit, cp_in[15:0].
  - Otherwise: v = cp_in - 32'h10000, 20 bits. hi = 16'hD800|v[19:10], lo = 16'hDC00|v[9:0].
- Serialisation:
  - A unit u is emitted as u[15:8],u[7:0] when BE, or u[7:0],u[15:8] when LE.
  - For a pair, all bytes of hi precede all bytes of lo.
- Handshake:
  - While dout_valid & ~dout_ready, dout, dout_last and the internal state hold stable.
  - On an output transfer with the index below n-1, advance to the next byte.
  - On an output transfer of the last byte, either load the next character (if one is accepted the same cycle) or clear dout_valid.
- dout_last = 1 exactly on byte n-1 of the character.
- cbe is latched on acceptance; toggling it mid-character does not affect that character.
- Reset:
  - dout=0, dout_valid=0, dout_last=0, busy=0, sub_cnt=0, n=0, i=0.
  - cp_ready is 1 in the first cycle after reset, unless the BOM option applies.
  - Reset asserted mid-character discards the pending bytes. Reset has priority over simultaneous transfers.
- sub_cnt saturates and never wraps.
- dout is 0 whenever dout_valid=0.

Optional Feature:
UTF16_BOM_EN
- Defined:
  - On the first cycle after rst deasserts, cbe is sampled and a 2-byte BOM is queued: FE FF if BE, FF FE if LE.
  - dout_last=1 on the BOM's second byte. cp_ready=0 until that byte transfers.
  - The BOM does not affect sub_cnt. It is emitted once per reset.
- Undefined: no BOM, and cp_ready=1 immediately after reset.

Test Plan:
1. LE, cp_in=32'h41, dout_ready=1 -> 41, 00 on consecutive cycles; dout_last on byte 2; sub_cnt=0.
2. BE, cp_in=32'h1F600 -> D8 3D DE 00; LE, same input -> 3D D8 00 DE; dout_last only on the 4th byte.
3. cp_in=32'hD800, then 32'h110000, then cp_err=1 with cp_in=32'h41 (BE) -> FF FD three times; sub_cnt=3.
4. Back-to-back 'A','B' with cp_valid=1 and dout_ready=1 -> 00 41 00 42 (BE) with no idle cycle. Hold dout_ready=0 for 5 cycles mid-character -> dout stable, cp_ready=0; resume -> correct remaining bytes.
5. Assert rst after the 2nd byte of U+1F600 -> next cycle dout_valid=0, sub_cnt=0. A new cp_in=32'hE9 (LE) -> E9 00.
6. With UTF16_BOM_EN and cbe=0 -> FF FE after reset, then the character bytes; cp_ready=0 during the BOM. Without the macro -> first byte is the character.
